// File: rtl/can_stuff_tx_if.sv
// can_stuff_tx_if: unstuffed bit stream handshake from the frame serializer
interface can_stuff_tx_if;
  logic din;
  logic din_valid;
  logic din_ready;
  modport master(output din, din_valid, input din_ready);
  modport slave(input din, din_valid, output din_ready);
endinterface

// File: rtl/can_stuff_tx.sv
// can_stuff_tx: CAN TX bit stuffer with bus readback for bit-error and arbitration-loss detection
module can_stuff_tx #(
  parameter int CONSEC = 5
) (
  input  logic          clkin,
  input  logic          rst_n,
  input  logic          bit_tick,
  input  logic          sample_tick,
  input  logic          en,
  input  logic          arb,
  input  logic          rxin,
  can_stuff_tx_if.slave data,
  output logic          txout,
  output logic          stuffed,
  output logic          bit_err,
  output logic          arb_lost,
  output logic          underrun
);
  localparam int CW = $clog2(CONSEC + 1);
  typedef enum logic {RUN, LOST} state_t;
  state_t state, state_nxt;
  logic last, pend;
  logic last_nxt, pend_nxt, txout_nxt, stuffed_nxt, bit_err_nxt, arb_lost_nxt, underrun_nxt;
  logic [CW-1:0] count, count_nxt, count_inc;
  assign data.din_ready = bit_tick & ~pend & (state == RUN);
  assign count_inc = (count == CW'(CONSEC)) ? count : count + CW'(1);
  always_comb begin
    state_nxt    = state;
    txout_nxt    = txout;
    stuffed_nxt  = stuffed;
    last_nxt     = last;
    count_nxt    = count;
    pend_nxt     = pend;
    arb_lost_nxt = arb_lost;
    bit_err_nxt  = 1'b0;
    underrun_nxt = 1'b0;
    if (state == RUN) begin
      // sample compares the bit currently on the line, before any bit_tick update
      if (sample_tick) begin
        if (arb & ~stuffed & txout & ~rxin) begin
          state_nxt    = LOST;
          arb_lost_nxt = 1'b1;
        end else begin
          bit_err_nxt = rxin != txout;
        end
      end
      if (bit_tick) begin
        if (pend) begin
          txout_nxt   = ~last;
          last_nxt    = ~last;
          stuffed_nxt = 1'b1;
          count_nxt   = en ? CW'(1) : '0;
          pend_nxt    = 1'b0;
        end else if (data.din_valid) begin
          txout_nxt   = data.din;
          stuffed_nxt = 1'b0;
          last_nxt    = data.din;
          count_nxt   = !en ? '0 : (data.din == last) ? count_inc : CW'(1);
          pend_nxt    = en & (count_nxt == CW'(CONSEC));
        end else begin
          txout_nxt    = 1'b1;
          stuffed_nxt  = 1'b0;
          underrun_nxt = 1'b1;
          last_nxt     = 1'b1;
          count_nxt    = '0;
          pend_nxt     = 1'b0;
        end
      end
    end else if (bit_tick) begin
      txout_nxt   = 1'b1;
      stuffed_nxt = 1'b0;
      if (!en) begin
        state_nxt    = RUN;
        arb_lost_nxt = 1'b0;
        count_nxt    = '0;
        last_nxt     = 1'b1;
        pend_nxt     = 1'b0;
      end
    end
  end
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      txout    <= 1'b1;
      stuffed  <= 1'b0;
      last     <= 1'b1;
      count    <= '0;
      pend     <= 1'b0;
      bit_err  <= 1'b0;
      arb_lost <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      txout    <= txout_nxt;
      stuffed  <= stuffed_nxt;
      last     <= last_nxt;
      count    <= count_nxt;
      pend     <= pend_nxt;
      bit_err  <= bit_err_nxt;
      arb_lost <= arb_lost_nxt;
      underrun <= underrun_nxt;
    end
  end
endmodule

// File: tb/tb_can_stuff_tx.sv
// tb_can_stuff_tx: directed stimulus, history-based reference model, per-cycle compare
module tb_can_stuff_tx;
  localparam int CONSEC = 5;
  logic clkin = 1'b0, rst_n = 1'b0;
  logic bit_tick = 1'b0, sample_tick = 1'b0, en = 1'b1, arb = 1'b0;
  logic rx_force = 1'b0, rx_val = 1'b1, rdy;
  logic rxin, txout, stuffed, bit_err, arb_lost, underrun;
  int errors = 0, checks = 0, n = 0;
  logic rec_tx[32], rec_st[32], rec_rdy[32], rec_un[32];
  can_stuff_tx_if bus();
  can_stuff_tx #(.CONSEC(CONSEC)) dut (
    .clkin(clkin), .rst_n(rst_n), .bit_tick(bit_tick), .sample_tick(sample_tick),
    .en(en), .arb(arb), .rxin(rxin), .data(bus.slave), .txout(txout), .stuffed(stuffed),
    .bit_err(bit_err), .arb_lost(arb_lost), .underrun(underrun)
  );
  assign rxin = rx_force ? rx_val : txout;
  always #5 clkin = ~clkin;
  // reference: transmitted-bit history since stuffing (re)started
  logic m_tx, m_st, m_err, m_under, m_lost, m_due, nlost;
  logic hist[$];
  function automatic int run_len();
    int k = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == hist[hist.size()-1]; i--) k++;
    return k;
  endfunction
  always @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      m_tx = 1; m_st = 0; m_err = 0; m_under = 0; m_lost = 0; m_due = 0;
      hist.delete();
    end else begin
      m_err = 0; m_under = 0; nlost = m_lost;
      if (!m_lost && sample_tick) begin
        if (arb && !m_st && m_tx && !rxin) nlost = 1;
        else if (rxin != m_tx) m_err = 1;
      end
      if (bit_tick) begin
        if (m_lost) begin
          m_tx = 1; m_st = 0;
          if (!en) begin nlost = 0; hist.delete(); m_due = 0; end
        end else if (m_due) begin
          m_tx = ~m_tx; m_st = 1; m_due = 0;
          hist.delete();
          if (en) hist.push_back(m_tx);
        end else if (bus.din_valid) begin
          m_tx = bus.din; m_st = 0;
          if (en) begin
            hist.push_back(bus.din);
            if (hist.size() > CONSEC) void'(hist.pop_front());
            m_due = run_len() >= CONSEC;
          end else begin
            hist.delete(); m_due = 0;
          end
        end else begin
          m_tx = 1; m_st = 0; m_under = 1; m_due = 0;
          hist.delete();
        end
      end
      m_lost = nlost;
    end
  end
  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clkin) begin
    chk("txout", txout, m_tx);
    chk("stuffed", stuffed, m_st);
    chk("bit_err", bit_err, m_err);
    chk("arb_lost", arb_lost, m_lost);
    chk("underrun", underrun, m_under);
    chk("din_ready", bus.din_ready, rst_n & bit_tick & ~m_due & ~m_lost);
  end
  task automatic step(input logic bt, input logic st);
    bit_tick = bt; sample_tick = st;
    #1 rdy = bus.din_ready;
    @(posedge clkin); #2;
    bit_tick = 0; sample_tick = 0;
  endtask
  task automatic tx_bit(input logic v, input logic d);
    bus.din_valid = v; bus.din = d;
    step(1, 0);
    rec_tx[n] = txout; rec_st[n] = stuffed; rec_rdy[n] = rdy; rec_un[n] = underrun;
    n++;
    step(0, 0); step(0, 1); step(0, 0);
  endtask
  initial begin
    #200000 $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [10:0] seq1;
    logic [12:0] exp_tx, exp_st;
    int idx, cnt;
    seq1 = 11'b00000111111; exp_tx = 13'b0000011111011; exp_st = 13'b0000010000100;
    bus.din = 0; bus.din_valid = 0;
    #2; step(0, 0); step(0, 0);
    chk("reset_txout", txout, 1'b1);
    rst_n = 1; step(0, 0);
    // five zeros then six ones, presented continuously
    n = 0; idx = 0;
    for (int t = 0; t < 20 && idx < 11; t++) begin
      tx_bit(1, seq1[10-idx]);
      if (rec_rdy[n-1]) idx++;
    end
    chk("t1_ticks13", n == 13, 1'b1);
    for (int i = 0; i < 13 && i < n; i++) begin
      chk($sformatf("t1_tx[%0d]", i), rec_tx[i], exp_tx[12-i]);
      chk($sformatf("t1_st[%0d]", i), rec_st[i], exp_st[12-i]);
    end
    cnt = 0;
    for (int i = 0; i < n; i++) if (!rec_rdy[i]) cnt++;
    chk("t1_ready_low2", cnt == 2, 1'b1);
    // stuffing disabled
    en = 0; n = 0;
    for (int i = 0; i < 6; i++) tx_bit(1, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t2_tx", rec_tx[i], 1'b0); chk("t2_st", rec_st[i], 1'b0); chk("t2_rdy", rec_rdy[i], 1'b1);
    end
    // stuff pending, then underrun
    en = 1; n = 0;
    for (int i = 0; i < 5; i++) tx_bit(1, 0);
    tx_bit(0, 0); tx_bit(0, 0);
    for (int i = 0; i < 5; i++) tx_bit(1, 1);
    tx_bit(0, 0);
    chk("t3_stuff_tx", rec_tx[5], 1'b1); chk("t3_stuff_st", rec_st[5], 1'b1);
    chk("t3_under_tx", rec_tx[6], 1'b1); chk("t3_under", rec_un[6], 1'b1);
    chk("t3_under_st", rec_st[6], 1'b0); chk("t3_run_st", rec_st[11], 1'b0);
    chk("t3_restart_tx", rec_tx[12], 1'b0); chk("t3_restart_st", rec_st[12], 1'b1);
    // bit error
    en = 0; arb = 0;
    tx_bit(1, 0);
    rx_force = 1; rx_val = 1; step(0, 1);
    chk("t4_bit_err", bit_err, 1'b1);
    rx_force = 0; step(0, 0);
    chk("t4_pulse_end", bit_err, 1'b0);
    step(0, 1);
    chk("t4_match", bit_err, 1'b0);
    // arbitration loss
    en = 1; arb = 1;
    tx_bit(1, 1);
    rx_force = 1; rx_val = 0; step(0, 1);
    rx_force = 0;
    chk("t5_lost", arb_lost, 1'b1); chk("t5_no_err", bit_err, 1'b0);
    n = 0;
    tx_bit(1, 0);
    chk("t5_rdy", rec_rdy[0], 1'b0); chk("t5_tx", rec_tx[0], 1'b1); chk("t5_held", arb_lost, 1'b1);
    arb = 0; en = 0;
    tx_bit(1, 0);
    chk("t5_clear", arb_lost, 1'b0);
    tx_bit(1, 0);
    chk("t5_resume_rdy", rec_rdy[2], 1'b1); chk("t5_resume_tx", rec_tx[2], 1'b0);
    // reset with a stuff bit pending
    en = 1;
    for (int i = 0; i < 5; i++) tx_bit(1, 0);
    chk("t6_pre_tx", txout, 1'b0);
    rst_n = 0; #1;
    chk("t6_async_tx", txout, 1'b1); chk("t6_async_st", stuffed, 1'b0);
    step(0, 0); step(0, 0);
    rst_n = 1; step(0, 0);
    n = 0;
    for (int i = 0; i < 7; i++) tx_bit(1, 0);
    cnt = 0;
    for (int i = 0; i < 7; i++) if (rec_st[i]) cnt++;
    chk("t6_first_st", rec_st[0], 1'b0); chk("t6_stuff6", rec_st[5], 1'b1);
    chk("t6_stuff_tx", rec_tx[5], 1'b1); chk("t6_one_stuff", cnt == 1, 1'b1);
    bus.din_valid = 0;
    step(0, 0); step(0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
